// File: rtl/inst_buffer_pkg.sv
// Shared widths, defaults and enable encodings for the instruction buffer.
// Optional feature macro: INSTBUF_DUAL_ISSUE_EN (second issue port).
package inst_buffer_pkg;
  localparam int unsigned InstBus     = 32;
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned DEPTH_DEF   = 16;
  localparam int unsigned SKID_DEF    = 2;

  typedef enum logic {
    ReadDisable = 1'b0,
    ReadEnable  = 1'b1
  } read_en_e;

  typedef enum logic {
    WriteDisable = 1'b0,
    WriteEnable  = 1'b1
  } write_en_e;

  typedef struct packed {
    logic [InstBus-1:0]     inst;
    logic [InstAddrBus-1:0] addr;
  } ib_entry_t;
endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-to-decode instruction buffer bus: icache push side, decode issue side, full back to PC.
// The issue1 signals are live only when INSTBUF_DUAL_ISSUE_EN is defined.
interface inst_buffer_if;
  import inst_buffer_pkg::*;

  logic                   flush;
  logic                   icache_valid_i;
  logic [InstBus-1:0]     icache_inst_i;
  logic [InstAddrBus-1:0] icache_addr_i;
  logic [1:0]             issue_cnt_i;
  logic                   issue0_valid_o;
  logic [InstBus-1:0]     issue0_inst_o;
  logic [InstAddrBus-1:0] issue0_addr_o;
  logic                   issue1_valid_o;
  logic [InstBus-1:0]     issue1_inst_o;
  logic [InstAddrBus-1:0] issue1_addr_o;
  logic                   instbuffer_full;

  modport master (
    output flush, icache_valid_i, icache_inst_i, icache_addr_i, issue_cnt_i,
    input  issue0_valid_o, issue0_inst_o, issue0_addr_o,
    input  issue1_valid_o, issue1_inst_o, issue1_addr_o, instbuffer_full
  );

  modport slave (
    input  flush, icache_valid_i, icache_inst_i, icache_addr_i, issue_cnt_i,
    output issue0_valid_o, issue0_inst_o, issue0_addr_o,
    output issue1_valid_o, issue1_inst_o, issue1_addr_o, instbuffer_full
  );
endinterface

// File: rtl/inst_buffer_mem.sv
// DEPTH x 64 entry storage: one synchronous write port, asynchronous read ports.
// Read port 1 exists only when INSTBUF_DUAL_ISSUE_EN is defined.
module inst_buffer_mem
  import inst_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  write_en_e     i_we,
  input  logic [AW-1:0] i_waddr,
  input  ib_entry_t     i_wdata,
  input  logic [AW-1:0] i_raddr0,
  output ib_entry_t     o_rdata0
`ifdef INSTBUF_DUAL_ISSUE_EN
  ,
  input  read_en_e      i_re1,
  input  logic [AW-1:0] i_raddr1,
  output ib_entry_t     o_rdata1
`endif
);

  ib_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we == WriteEnable) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];

`ifdef INSTBUF_DUAL_ISSUE_EN
  assign o_rdata1 = (i_re1 == ReadEnable) ? r_mem[i_raddr1] : '0;
`endif

endmodule

// File: rtl/inst_buffer.sv
// Instruction FIFO between icache and decode with skid headroom and one-cycle flush.
// Define INSTBUF_DUAL_ISSUE_EN to enable the second issue port and two-entry pops.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned SKID  = SKID_DEF
) (
  input logic         clk,
  input logic         reset,
  inst_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullDepth = CW'(DEPTH);
  localparam logic [CW-1:0] FullMark  = CW'(DEPTH - SKID);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_full;

  logic          w_push;
  logic [1:0]    w_req;
  logic [1:0]    w_pop;
  logic [CW-1:0] w_count_next;
  ib_entry_t     w_wdata;
  ib_entry_t     w_rd0;
  write_en_e     w_we;

  always_comb begin
    w_push = bus.icache_valid_i && !bus.flush && (r_count < FullDepth);
`ifdef INSTBUF_DUAL_ISSUE_EN
    w_req = (bus.issue_cnt_i == 2'd3) ? 2'd2 : bus.issue_cnt_i;
`else
    w_req = (bus.issue_cnt_i != 2'd0) ? 2'd1 : 2'd0;
`endif
    // When fewer entries exist than requested, r_count is 0 or 1 and fits in two bits
    w_pop        = (CW'(w_req) > r_count) ? r_count[1:0] : w_req;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_we         = w_push ? WriteEnable : WriteDisable;
    w_wdata      = '{inst: bus.icache_inst_i, addr: bus.icache_addr_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_head  <= r_head + AW'(w_pop);
      r_tail  <= r_tail + AW'(w_push);
      r_count <= w_count_next;
      r_full  <= (w_count_next >= FullMark);
    end
  end

`ifdef INSTBUF_DUAL_ISSUE_EN
  ib_entry_t     w_rd1;
  logic [AW-1:0] w_head1;

  assign w_head1 = r_head + AW'(1);

  inst_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (r_tail),
    .i_wdata  (w_wdata),
    .i_raddr0 (r_head),
    .o_rdata0 (w_rd0),
    .i_re1    (ReadEnable),
    .i_raddr1 (w_head1),
    .o_rdata1 (w_rd1)
  );

  assign bus.issue1_valid_o = (r_count >= CW'(2));
  assign bus.issue1_inst_o  = w_rd1.inst;
  assign bus.issue1_addr_o  = w_rd1.addr;
`else
  inst_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .i_we     (w_we),
    .i_waddr  (r_tail),
    .i_wdata  (w_wdata),
    .i_raddr0 (r_head),
    .o_rdata0 (w_rd0)
  );

  assign bus.issue1_valid_o = 1'b0;
  assign bus.issue1_inst_o  = '0;
  assign bus.issue1_addr_o  = '0;
`endif

  assign bus.issue0_valid_o  = (r_count != '0);
  assign bus.issue0_inst_o   = w_rd0.inst;
  assign bus.issue0_addr_o   = w_rd0.addr;
  assign bus.instbuffer_full = r_full;

  // Fetch must stop within SKID responses of full rising; a push at DEPTH is lost
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(bus.icache_valid_i && !bus.flush && (r_count == FullDepth)));

endmodule
